mem_stage: RTL and testbench

//  EX/MEM pipeline register plus MEM stage of the 5-stage MIPS core; consumes EX outputs each cycle.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_dm.sv | 21 ++
 rtl/mem_stage.sv | 85 ++++++++
 tb/tb_mem_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: memory-op opcodes, reset values and the M-stage opcode decoder.
package mem_stage_pkg;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [31:0] PC_RESET    = 32'h0;
  localparam logic [31:0] INSTR_RESET = 32'h0;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  typedef struct packed {
    logic  load;
    logic  store;
    logic  uns;
    size_e size;
  } mop_t;

  function automatic mop_t decode(input logic [5:0] op);
    mop_t d;
    d.load  = op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    d.store = op inside {OP_SW, OP_SH, OP_SB};
    d.uns   = op inside {OP_LHU, OP_LBU};
    d.size  = (op inside {OP_LW, OP_SW}) ? SZ_W : (op inside {OP_LH, OP_LHU, OP_SH}) ? SZ_H : SZ_B;
    return d;
  endfunction
endpackage

// File: rtl/mem_dm.sv
// mem_dm: data memory with byte-enable write port, asynchronous read and asynchronous clear.
module mem_dm #(
  parameter int WORDS = 3072,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [WORDS];
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
    else
      for (int b = 0; b < 4; b++) if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
  // Index space may exceed the array when WORDS is not a power of two.
  assign o_rdata = (32'(i_addr) < 32'(WORDS)) ? r_mem[i_addr] : '0;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register plus MEM stage (data memory, store lanes, load extension).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_M,
  input  logic        Flush_M,
  input  logic [31:0] PC_EX,
  input  logic [31:0] Instr_EX,
  input  logic [31:0] ALURes_EX,
  input  logic [31:0] RegData2_EX,
  input  logic [4:0]  RegAddr_EX,
  output logic [31:0] PC_M,
  output logic [31:0] Instr_M,
  output logic [31:0] ALURes_M,
  output logic [4:0]  RegAddr_M,
  output logic [31:0] MemData_M,
  output logic [31:0] FWD_M,
  output logic        IsLoad_M,
  output logic        AdEL_M,
  output logic        AdES_M
);
  localparam int AW = $clog2(DM_WORDS);
  logic [31:0] r_pc, r_instr, r_alu, r_rd2;
  logic [4:0]  r_rd;
  mop_t        w_op;
  logic        w_err;
  logic [3:0]  w_be, w_we;
  logic [31:0] w_wdata, w_rdata;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_ff @(posedge clk or negedge reset)
    if (!reset || Flush_M) begin
      r_pc    <= PC_RESET;
      r_instr <= INSTR_RESET;
      r_alu   <= '0;
      r_rd2   <= '0;
      r_rd    <= '0;
    end else if (!Stall_M) begin
      r_pc    <= PC_EX;
      r_instr <= Instr_EX;
      r_alu   <= ALURes_EX;
      r_rd2   <= RegData2_EX;
      r_rd    <= RegAddr_EX;
    end

  assign w_op  = decode(r_instr[31:26]);
  assign w_err = (r_alu >= 32'(4*DM_WORDS))
               | ((w_op.size == SZ_W) ? |r_alu[1:0] : (w_op.size == SZ_H) ? r_alu[0] : 1'b0);

  assign w_be    = (w_op.size == SZ_W) ? 4'hF : (w_op.size == SZ_H) ? (r_alu[1] ? 4'hC : 4'h3)
                 : 4'b0001 << r_alu[1:0];
  assign w_we    = (w_op.store && !w_err && !Stall_M) ? w_be : 4'h0;
  assign w_wdata = (w_op.size == SZ_W) ? r_rd2 : (w_op.size == SZ_H) ? {2{r_rd2[15:0]}} : {4{r_rd2[7:0]}};

  mem_dm #(.WORDS(DM_WORDS)) u_dm (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_addr  (r_alu[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_byte = w_rdata[{r_alu[1:0], 3'b000} +: 8];
  assign w_half = r_alu[1] ? w_rdata[31:16] : w_rdata[15:0];

  assign MemData_M = !(w_op.load && !w_err) ? '0
                   : (w_op.size == SZ_W) ? w_rdata
                   : (w_op.size == SZ_H) ? {{16{!w_op.uns & w_half[15]}}, w_half}
                   : {{24{!w_op.uns & w_byte[7]}}, w_byte};

  assign PC_M      = r_pc;
  assign Instr_M   = r_instr;
  assign ALURes_M  = r_alu;
  assign RegAddr_M = r_rd;
  assign FWD_M     = r_alu;
  assign IsLoad_M  = w_op.load;
  assign AdEL_M    = w_op.load & w_err;
  assign AdES_M    = w_op.store & w_err;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a byte-array reference model.
module tb_mem_stage;
  localparam int DMW = 3072;
  localparam int DMB = 4*DMW;

  logic        clk = 0, reset = 0, Stall_M = 0, Flush_M = 0;
  logic [31:0] PC_EX = 0, Instr_EX = 0, ALURes_EX = 0, RegData2_EX = 0;
  logic [4:0]  RegAddr_EX = 0;
  logic [31:0] PC_M, Instr_M, ALURes_M, MemData_M, FWD_M;
  logic [4:0]  RegAddr_M;
  logic        IsLoad_M, AdEL_M, AdES_M;

  int n_checks = 0, n_errors = 0;
  logic [7:0]  mdl_mem [DMB];
  logic [31:0] mdl_pc, mdl_instr, mdl_alu, mdl_rd2;
  logic [4:0]  mdl_ra;
  logic [5:0]  ops [9] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2b, 6'h29, 6'h28, 6'h00};
  logic [5:0]  r_op;
  logic [31:0] r_a;
  int          sel;

  always #5 clk = ~clk;

  mem_stage #(.DM_WORDS(DMW)) dut (
    .clk(clk), .reset(reset), .Stall_M(Stall_M), .Flush_M(Flush_M),
    .PC_EX(PC_EX), .Instr_EX(Instr_EX), .ALURes_EX(ALURes_EX), .RegData2_EX(RegData2_EX),
    .RegAddr_EX(RegAddr_EX), .PC_M(PC_M), .Instr_M(Instr_M), .ALURes_M(ALURes_M),
    .RegAddr_M(RegAddr_M), .MemData_M(MemData_M), .FWD_M(FWD_M), .IsLoad_M(IsLoad_M),
    .AdEL_M(AdEL_M), .AdES_M(AdES_M)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int op_size(input logic [5:0] op);
    if (op inside {6'h23, 6'h2b}) return 4;
    if (op inside {6'h21, 6'h25, 6'h29}) return 2;
    if (op inside {6'h20, 6'h24, 6'h28}) return 1;
    return 0;
  endfunction

  function automatic bit is_load(input logic [5:0] op);
    return op inside {6'h23, 6'h21, 6'h25, 6'h20, 6'h24};
  endfunction

  function automatic bit is_store(input logic [5:0] op);
    return op inside {6'h2b, 6'h29, 6'h28};
  endfunction

  function automatic bit addr_err(input logic [5:0] op, input logic [31:0] a);
    int s;
    s = op_size(op);
    return s != 0 && ((a % s) != 0 || a >= DMB);
  endfunction

  function automatic logic [31:0] exp_load();
    int s;
    logic [31:0] v;
    s = op_size(mdl_instr[31:26]);
    v = 0;
    if (!is_load(mdl_instr[31:26]) || addr_err(mdl_instr[31:26], mdl_alu)) return 0;
    for (int k = 0; k < s; k++) v |= 32'(mdl_mem[int'(mdl_alu) + k]) << (8*k);
    if (s < 4 && mdl_instr[31:26] inside {6'h20, 6'h21} && v[8*s-1]) v |= 32'hFFFF_FFFF << (8*s);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DMB; i++) mdl_mem[i] = 0;
    {mdl_pc, mdl_instr, mdl_alu, mdl_rd2, mdl_ra} = '0;
  endtask

  task automatic check_all(input string tag);
    logic [5:0] op;
    op = mdl_instr[31:26];
    check({tag, " pc"}, PC_M, mdl_pc);
    check({tag, " instr"}, Instr_M, mdl_instr);
    check({tag, " alu"}, ALURes_M, mdl_alu);
    check({tag, " regaddr"}, 32'(RegAddr_M), 32'(mdl_ra));
    check({tag, " fwd"}, FWD_M, mdl_alu);
    check({tag, " isload"}, 32'(IsLoad_M), 32'(is_load(op)));
    check({tag, " adel"}, 32'(AdEL_M), 32'(is_load(op) && addr_err(op, mdl_alu)));
    check({tag, " ades"}, 32'(AdES_M), 32'(is_store(op) && addr_err(op, mdl_alu)));
    check({tag, " memdata"}, MemData_M, exp_load());
  endtask

  task automatic cyc(input string tag, input logic [5:0] op, input logic [31:0] alu,
                     input logic [31:0] rd2, input bit stall, input bit flush);
    PC_EX       = $urandom;
    Instr_EX    = {op, 26'($urandom)};
    ALURes_EX   = alu;
    RegData2_EX = rd2;
    RegAddr_EX  = 5'($urandom);
    Stall_M     = stall;
    Flush_M     = flush;
    @(posedge clk);
    if (is_store(mdl_instr[31:26]) && !addr_err(mdl_instr[31:26], mdl_alu) && !stall)
      for (int k = 0; k < op_size(mdl_instr[31:26]); k++) mdl_mem[int'(mdl_alu) + k] = mdl_rd2[8*k +: 8];
    if (flush) {mdl_pc, mdl_instr, mdl_alu, mdl_rd2, mdl_ra} = '0;
    else if (!stall) begin
      mdl_pc = PC_EX; mdl_instr = Instr_EX; mdl_alu = ALURes_EX; mdl_rd2 = RegData2_EX; mdl_ra = RegAddr_EX;
    end
    #1 check_all(tag);
  endtask

  initial begin
    model_clear();
    PC_EX = 32'h400; Instr_EX = {6'h2b, 26'h1}; ALURes_EX = 32'h10; RegData2_EX = 32'hFFFF; RegAddr_EX = 5'd7;
    repeat (3) @(posedge clk);
    #1 check_all("reset_hold");
    @(negedge clk) reset = 1;

    cyc("sw10", 6'h2b, 32'h10, 32'h12345678, 0, 0);
    cyc("lw10", 6'h23, 32'h10, 0, 0, 0);          check("lw10 value", MemData_M, 32'h12345678);
    cyc("lb13", 6'h20, 32'h13, 0, 0, 0);          check("lb13 value", MemData_M, 32'h00000012);
    cyc("sb10", 6'h28, 32'h10, 32'h80, 0, 0);
    cyc("lb10", 6'h20, 32'h10, 0, 0, 0);          check("lb10 value", MemData_M, 32'hFFFFFF80);
    cyc("lbu10", 6'h24, 32'h10, 0, 0, 0);         check("lbu10 value", MemData_M, 32'h00000080);
    cyc("sh22", 6'h29, 32'h22, 32'hBEEF, 0, 0);
    cyc("lw20", 6'h23, 32'h20, 0, 0, 0);          check("lw20 value", MemData_M, 32'hBEEF0000);
    cyc("lh22", 6'h21, 32'h22, 0, 0, 0);          check("lh22 value", MemData_M, 32'hFFFFBEEF);
    cyc("lhu22", 6'h25, 32'h22, 0, 0, 0);         check("lhu22 value", MemData_M, 32'h0000BEEF);
    cyc("lw11", 6'h23, 32'h11, 0, 0, 0);          check("lw11 adel", 32'(AdEL_M), 1);
    check("lw11 data", MemData_M, 0);
    cyc("sw12", 6'h2b, 32'h12, 32'hDEADBEEF, 0, 0); check("sw12 ades", 32'(AdES_M), 1);
    cyc("lw10b", 6'h23, 32'h10, 0, 0, 0);         check("lw10 unchanged", MemData_M, 32'h12345680);
    cyc("swoor", 6'h2b, 32'(DMB), 32'hDEADBEEF, 0, 0); check("swoor ades", 32'(AdES_M), 1);
    cyc("lwtop", 6'h23, 32'(DMB - 4), 0, 0, 0);   check("lwtop value", MemData_M, 0);

    cyc("sw30", 6'h2b, 32'h30, 32'hCAFEF00D, 0, 0);
    repeat (3) begin
      cyc("stall", 6'h23, 32'h30, 0, 1, 0);
      check("stall hold", Instr_M[31:26], 6'h2b);
    end
    cyc("lw30", 6'h23, 32'h30, 0, 0, 0);          check("lw30 value", MemData_M, 32'hCAFEF00D);
    cyc("sw34", 6'h2b, 32'h34, 32'h11111111, 0, 0);
    cyc("stflush", 6'h23, 32'h34, 0, 1, 1);       check("bubble instr", Instr_M, 0);
    check("bubble regaddr", 32'(RegAddr_M), 0);
    cyc("lw34", 6'h23, 32'h34, 0, 0, 0);          check("lw34 value", MemData_M, 0);
    cyc("sw40", 6'h2b, 32'h40, 32'hA5A5A5A5, 0, 0);
    cyc("lw40", 6'h23, 32'h40, 0, 0, 0);          check("lw40 value", MemData_M, 32'hA5A5A5A5);
    check("fwd40", FWD_M, 32'h40);

    reset = 0;
    model_clear();
    #1 check_all("midreset");
    @(negedge clk) reset = 1;
    cyc("lw10r", 6'h23, 32'h10, 0, 0, 0);         check("dm cleared", MemData_M, 0);

    for (int i = 0; i < 400; i++) begin
      r_op = ops[$urandom_range(0, 8)];
      sel  = $urandom_range(0, 19);
      r_a  = sel < 16 ? 32'($urandom_range(0, 255)) : sel < 18 ? 32'(DMB - $urandom_range(1, 8))
           : sel == 18 ? 32'(DMB + $urandom_range(0, 8)) : $urandom;
      if ($urandom_range(0, 3) != 0 && op_size(r_op) != 0) r_a = r_a & ~32'(op_size(r_op) - 1);
      cyc("rnd", r_op, r_a, $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
